// File: rtl/wmul_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wallace-tree multiplier.
package wmul_pkg;

  localparam int unsigned WMUL_W_DEFAULT = 8;

  typedef struct packed {
    logic valid;
    logic sgn;
    logic acc_clr;
  } stage_t;

  function automatic int unsigned pp_rows(input int unsigned w);
    return w + 1;
  endfunction

  // Rows left after one level of 3:2 compression.
  function automatic int unsigned csa_step(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int unsigned rows_after(input int unsigned n, input int unsigned k);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < k; i++) r = csa_step(r);
    return r;
  endfunction

  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned r;
    int unsigned l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = csa_step(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/wmul_csa_row.sv
// One N-bit 3:2 carry-save compressor row; carry is returned pre-shifted by one bit.
module wmul_csa_row #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  logic [N-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]);
  assign c   = {maj, 1'b0};

endmodule

// File: rtl/wallace_multiplier_pipe.sv
// 3-stage pipelined signed/unsigned Wallace-tree multiplier with a global-stall handshake.
// Optional running accumulator enabled by defining WMUL_ACCUM_EN.
module wallace_multiplier_pipe
  import wmul_pkg::*;
#(
  parameter int unsigned W     = WMUL_W_DEFAULT,
  parameter int unsigned ACC_G = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef WMUL_ACCUM_EN
  input  logic             in_acc_clr,
  output logic [2*W+ACC_G-1:0] out_acc,
`endif
  output logic [2*W-1:0]   out_product
);

  localparam int unsigned P  = 2 * W;
  // The negated MSB row's "+1" travels as its own single-bit row.
  localparam int unsigned NR = pp_rows(W) + 1;
  localparam int unsigned LV = csa_levels(NR);

  logic         adv;
  logic         clr_in;
  stage_t       st1, st2;
  logic [W-1:0] a1, b1;
  logic [P-1:0] pp [NR];
  logic [P-1:0] sum2, carry2, prod;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef WMUL_ACCUM_EN
  assign clr_in = in_acc_clr;
`else
  assign clr_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else if (adv) begin
      st1.valid   <= in_valid;
      st1.sgn     <= in_signed;
      st1.acc_clr <= clr_in;
      a1          <= in_a;
      b1          <= in_b;
    end
  end

  // Row W carries weight -2^W when the extended multiplier is negative: ~x + 1.
  always_comb begin
    logic [P-1:0] ax;
    logic         bx;
    ax = {{W{st1.sgn & a1[W-1]}}, a1};
    bx = st1.sgn & b1[W-1];
    for (int unsigned i = 0; i < W; i++) pp[i] = b1[i] ? (ax << i) : '0;
    pp[W]   = bx ? ~(ax << W) : '0;
    pp[W+1] = P'(bx);
  end

  for (genvar k = 0; k <= LV; k++) begin : lvl
    localparam int unsigned NK = rows_after(NR, k);
    logic [P-1:0] r [NK];
    if (k == 0) begin : g_init
      assign r = pp;
    end else begin : g_red
      localparam int unsigned NP = rows_after(NR, k - 1);
      for (genvar g = 0; g < NP / 3; g++) begin : g_csa
        wmul_csa_row #(.N(P)) u_csa (
          .x(lvl[k-1].r[3*g]),
          .y(lvl[k-1].r[3*g+1]),
          .z(lvl[k-1].r[3*g+2]),
          .s(r[2*g]),
          .c(r[2*g+1])
        );
      end
      for (genvar j = 0; j < NP % 3; j++) begin : g_pass
        assign r[2*(NP/3)+j] = lvl[k-1].r[3*(NP/3)+j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st2    <= '0;
      sum2   <= '0;
      carry2 <= '0;
    end else if (adv) begin
      st2    <= st1;
      sum2   <= lvl[LV].r[0];
      carry2 <= lvl[LV].r[1];
    end
  end

  assign prod = sum2 + carry2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (adv) begin
      out_valid <= st2.valid;
      if (st2.valid) out_product <= prod;
    end
  end

`ifdef WMUL_ACCUM_EN
  logic [P+ACC_G-1:0] pext;
  assign pext = {{ACC_G{st2.sgn & prod[P-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc <= '0;
    end else if (adv && st2.valid) begin
      out_acc <= st2.acc_clr ? pext : out_acc + pext;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{st2.sgn, st2.acc_clr, ACC_G[0]};
`endif

endmodule
